// File: rtl/ddr2_cmd_sequencer.sv
// Close-page DDR2 command sequencer: turns one host request at a time into
// ACTIVATE -> READ/WRITE -> PRECHARGE pin sequences with registered pin outputs.
module ddr2_cmd_sequencer #(
  parameter int T_RCD    = 2,
  parameter int T_RP     = 2,
  parameter int INIT_CYC = 4,
  parameter int RD_LAT   = 1
) (
  input  logic        ck,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_ba,
  input  logic [12:0] req_row,
  input  logic [9:0]  req_col,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        cke,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [1:0]  ba,
  output logic [12:0] addr,
  inout  wire  [15:0] dq,
  inout  wire  [1:0]  dqs,
  inout  wire  [1:0]  dqs_n,
  output logic [1:0]  dm_rdqs,
  output logic        odt
);

  localparam logic [3:0] S_INIT    = 4'd0;
  localparam logic [3:0] S_IDLE    = 4'd1;
  localparam logic [3:0] S_ACT     = 4'd2;
  localparam logic [3:0] S_RW      = 4'd3;
  localparam logic [3:0] S_WDATA0  = 4'd4;
  localparam logic [3:0] S_WDATA1  = 4'd5;
  localparam logic [3:0] S_RD_WAIT = 4'd6;
  localparam logic [3:0] S_PRE     = 4'd7;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  localparam logic [7:0] L_INIT = 8'(INIT_CYC - 1);
  localparam logic [7:0] L_RCD  = 8'(T_RCD - 1);
  localparam logic [7:0] L_RP   = 8'(T_RP - 1);
  localparam logic [7:0] L_RD   = 8'(RD_LAT);

  logic [3:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic [9:0]  r_col;
  logic [15:0] r_wdata;
  logic [3:0]  r_cmd;
  logic [1:0]  r_ba;
  logic [12:0] r_addr;
  logic [15:0] r_dq;
  logic        r_dq_oe;
  logic [1:0]  r_dqs;
  logic [1:0]  r_dqs_n;
  logic        r_odt;
  logic        r_cke;
  logic        r_ready;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_rdata;

  // r_cnt counts edges spent in the current timed state; outputs reflect the state just entered.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_state     <= S_INIT;
      r_cnt       <= 8'd0;
      r_we        <= 1'b0;
      r_col       <= 10'd0;
      r_wdata     <= 16'd0;
      r_cmd       <= 4'b1111;
      r_ba        <= 2'd0;
      r_addr      <= 13'd0;
      r_dq        <= 16'd0;
      r_dq_oe     <= 1'b0;
      r_dqs       <= 2'b00;
      r_dqs_n     <= 2'b11;
      r_odt       <= 1'b0;
      r_cke       <= 1'b0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 16'd0;
    end else begin
      r_cke       <= 1'b1;
      r_cmd       <= CMD_NOP;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (r_cnt == L_INIT) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_IDLE: begin
          if (req_valid && r_ready) begin
            r_we    <= req_we;
            r_col   <= req_col;
            r_wdata <= req_wdata;
            r_cmd   <= CMD_ACT;
            r_ba    <= req_ba;
            r_addr  <= req_row;
            r_cnt   <= 8'd0;
            r_state <= S_ACT;
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_ACT: begin
          if (r_cnt == L_RCD) begin
            r_cmd   <= r_we ? CMD_WR : CMD_RD;
            r_addr  <= {3'b000, r_col};
            r_state <= S_RW;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RW: begin
          if (r_we) begin
            r_dq    <= r_wdata;
            r_dq_oe <= 1'b1;
            r_dqs   <= 2'b00;
            r_dqs_n <= 2'b11;
            r_odt   <= 1'b1;
            r_state <= S_WDATA0;
          end else begin
            r_cnt   <= 8'd1;
            r_state <= S_RD_WAIT;
            if (L_RD == 8'd1) begin
              r_rsp_rdata <= dq;
              r_rsp_valid <= 1'b1;
            end
          end
        end
        S_WDATA0: begin
          r_dqs   <= 2'b11;
          r_dqs_n <= 2'b00;
          r_state <= S_WDATA1;
        end
        S_WDATA1: begin
          r_dq_oe <= 1'b0;
          r_odt   <= 1'b0;
          r_cmd   <= CMD_PRE;
          r_addr  <= 13'd0;
          r_cnt   <= 8'd0;
          r_state <= S_PRE;
        end
        S_RD_WAIT: begin
          if (r_cnt == L_RD) begin
            r_cmd   <= CMD_PRE;
            r_addr  <= 13'd0;
            r_cnt   <= 8'd0;
            r_state <= S_PRE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt + 8'd1 == L_RD) begin
              r_rsp_rdata <= dq;
              r_rsp_valid <= 1'b1;
            end
          end
        end
        S_PRE: begin
          if (r_cnt == L_RP) begin
            r_ready <= 1'b1;
            r_cnt   <= 8'd0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_cnt   <= 8'd0;
          r_state <= S_INIT;
        end
      endcase
    end
  end

  assign {cs_n, ras_n, cas_n, we_n} = r_cmd;
  assign cke       = r_cke;
  assign ba        = r_ba;
  assign addr      = r_addr;
  assign odt       = r_odt;
  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign dm_rdqs   = 2'b00;

  assign dq    = r_dq_oe ? r_dq    : 16'bz;
  assign dqs   = r_dq_oe ? r_dqs   : 2'bz;
  assign dqs_n = r_dq_oe ? r_dqs_n : 2'bz;

endmodule

// File: tb/tb_ddr2_cmd_sequencer.sv
// Directed bench for ddr2_cmd_sequencer: walks write, read, back-to-back,
// mid-write reset and unwritten-read sequences edge by edge.
module tb_ddr2_cmd_sequencer;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;

  logic        ck;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_ba;
  logic [12:0] req_row;
  logic [9:0]  req_col;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [12:0] addr;
  wire  [15:0] dq;
  wire  [1:0]  dqs;
  wire  [1:0]  dqs_n;
  logic [1:0]  dm_rdqs;
  logic        odt;
  logic [3:0]  cmd;

  int checks;
  int errors;
  int pulseCount;

  logic        drvOn;
  logic [15:0] drvData;
  logic [12:0] actRow;
  logic [24:0] wrKey;
  logic [15:0] mem [logic [24:0]];

  assign cmd = {cs_n, ras_n, cas_n, we_n};
  assign dq  = drvOn ? drvData : 16'bz;

  ddr2_cmd_sequencer dut (
    .ck(ck), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_ba(req_ba), .req_row(req_row), .req_col(req_col), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr), .dq(dq), .dqs(dqs), .dqs_n(dqs_n),
    .dm_rdqs(dm_rdqs), .odt(odt)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Minimal DRAM: latches the row on ACT, stores write data on the dqs high
  // phase, and drives stored data across the capture edge after a RD.
  always @(negedge ck) begin
    if (drvOn) drvOn = 1'b0;
    if (!reset) begin
      if (cmd == ACT) actRow = addr;
      if (cmd == WR) wrKey = {ba, actRow, addr[9:0]};
      if (cmd == RD && mem.exists({ba, actRow, addr[9:0]})) begin
        drvData = mem[{ba, actRow, addr[9:0]}];
        drvOn   = 1'b1;
      end
      if (odt && dqs == 2'b11) mem[wrKey] = dq;
      if (rsp_valid) pulseCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge ck);
    #1;
  endtask

  // Issues one request from IDLE and checks every edge through the return to IDLE.
  task automatic applyStimulus(input logic we, input logic [1:0] b, input logic [12:0] row,
                               input logic [9:0] col, input logic [15:0] wd, input bit hold,
                               input bit chkData, input logic [15:0] expData);
    req_we = we; req_ba = b; req_row = row; req_col = col; req_wdata = wd;
    req_valid = 1'b1;
    tick;
    checkOutput("act_cmd", cmd, ACT);
    checkOutput("act_ba", ba, b);
    checkOutput("act_addr", addr, row);
    checkOutput("busy_ready", req_ready, 0);
    if (!hold) req_valid = 1'b0;
    tick;
    checkOutput("rcd_nop", cmd, NOP);
    tick;
    checkOutput("rw_cmd", cmd, we ? WR : RD);
    checkOutput("rw_addr", addr, {3'b000, col});
    checkOutput("rw_ba", ba, b);
    if (we) begin
      tick;
      checkOutput("wd0_cmd", cmd, NOP);
      checkOutput("wd0_odt", odt, 1);
      checkOutput("wd0_dq", dq, wd);
      checkOutput("wd0_dqs", {dqs, dqs_n}, 4'b0011);
      tick;
      checkOutput("wd1_dqs", {dqs, dqs_n}, 4'b1100);
      checkOutput("wd1_dq", dq, wd);
      checkOutput("wd1_odt", odt, 1);
    end else begin
      tick;
      checkOutput("rd_valid", rsp_valid, 1);
      if (chkData) checkOutput("rd_data", rsp_rdata, expData);
      checkOutput("rd_wait_cmd", cmd, NOP);
      checkOutput("rd_wait_addr", addr, {3'b000, col});
      checkOutput("rd_wait_ba", ba, b);
    end
    tick;
    checkOutput("pre_cmd", cmd, PRE);
    checkOutput("pre_ba", ba, b);
    checkOutput("pre_a10", addr[10], 0);
    checkOutput("pre_odt", odt, 0);
    checkOutput("pre_valid", rsp_valid, 0);
    tick;
    checkOutput("rp_nop", cmd, NOP);
    checkOutput("rp_ready", req_ready, 0);
    tick;
    checkOutput("idle_ready", req_ready, 1);
    checkOutput("idle_cmd", cmd, NOP);
  endtask

  // Walks the INIT window after reset release: cke at edge 1, ready at edge 4.
  task automatic releaseReset;
    reset = 1'b0;
    tick;
    checkOutput("init_cke", cke, 1);
    checkOutput("init_cmd", cmd, NOP);
    checkOutput("init_ready1", req_ready, 0);
    tick;
    checkOutput("init_cmd2", cmd, NOP);
    tick;
    checkOutput("init_ready3", req_ready, 0);
    checkOutput("init_cmd3", cmd, NOP);
    tick;
    checkOutput("init_ready4", req_ready, 1);
    checkOutput("init_cmd4", cmd, NOP);
  endtask

  initial begin
    checks = 0; errors = 0; pulseCount = 0;
    drvOn = 1'b0; drvData = 16'd0; actRow = 13'd0; wrKey = 25'd0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_ba = 2'd0;
    req_row = 13'd0; req_col = 10'd0; req_wdata = 16'd0;

    repeat (3) tick;
    checkOutput("rst_cke", cke, 0);
    checkOutput("rst_cmd", cmd, 4'b1111);
    checkOutput("rst_ba_addr", {ba, addr}, 0);
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_rsp", {rsp_valid, rsp_rdata}, 0);
    checkOutput("rst_odt", odt, 0);
    checkOutput("dm_rdqs", dm_rdqs, 0);

    releaseReset;

    applyStimulus(1'b1, 2'd1, 13'h0123, 10'h045, 16'hBEEF, 1'b0, 1'b0, 16'h0000);
    applyStimulus(1'b0, 2'd1, 13'h0123, 10'h045, 16'h0000, 1'b0, 1'b1, 16'hBEEF);

    applyStimulus(1'b1, 2'd2, 13'h1FFF, 10'h3FF, 16'h1234, 1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 2'd1, 13'h0123, 10'h045, 16'h0000, 1'b1, 1'b1, 16'hBEEF);
    applyStimulus(1'b0, 2'd2, 13'h1FFF, 10'h3FF, 16'h0000, 1'b0, 1'b1, 16'h1234);

    applyStimulus(1'b0, 2'd0, 13'h0000, 10'h007, 16'h0000, 1'b0, 1'b0, 16'h0000);
    checkOutput("pulse_count", pulseCount, 4);

    // Write that is cut off by reset while the dqs high phase is on the pins.
    req_we = 1'b1; req_ba = 2'd3; req_row = 13'h0042; req_col = 10'h011;
    req_wdata = 16'hCAFE; req_valid = 1'b1;
    tick;
    checkOutput("mid_act", cmd, ACT);
    req_valid = 1'b0;
    repeat (3) tick;
    tick;
    checkOutput("mid_wd1_dqs", {dqs, dqs_n}, 4'b1100);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_cke", cke, 0);
    checkOutput("mid_rst_cmd", cmd, 4'b1111);
    checkOutput("mid_rst_odt", odt, 0);
    checkOutput("mid_rst_ready", req_ready, 0);
    checkOutput("mid_rst_ba_addr", {ba, addr}, 0);
    repeat (2) tick;
    checkOutput("mid_rst_valid", rsp_valid, 0);
    releaseReset;
    checkOutput("mid_pulse_count", pulseCount, 4);

    applyStimulus(1'b0, 2'd1, 13'h0123, 10'h045, 16'h0000, 1'b0, 1'b1, 16'hBEEF);
    checkOutput("final_pulse_count", pulseCount, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
